// File: rtl/int_vector_ctl_pkg.sv
// Shared definitions for the interrupt vector controller: command codes,
// IRQ count and vector field widths.
package int_pkg;

  localparam int IRQ_N  = 8;
  localparam int IDX_W  = 3;
  localparam int BASE_W = 6;
  localparam int DATA_W = 12;

  typedef enum logic [2:0] {
    CMD_NOP        = 3'b000,
    CMD_LOAD_MASK  = 3'b001,
    CMD_LOAD_BASE  = 3'b010,
    CMD_EOI        = 3'b011,
    CMD_CLEAR_PEND = 3'b100,
    CMD_READ       = 3'b101,
    CMD_MASK_ALL   = 3'b110,
    CMD_UNMASK_ALL = 3'b111
  } cmd_e;

  function automatic logic [DATA_W-1:0] make_vector(
    input logic [BASE_W-1:0] base,
    input logic              spur,
    input logic [IDX_W-1:0]  idx
  );
    return {base, spur, idx, 2'b00};
  endfunction

endpackage

// File: rtl/int_vector_ctl_if.sv
// Request/command/strobe bundle between the microprogram sequencer side and
// the interrupt vector controller.
interface int_vector_ctl_if;
  import int_pkg::*;

  logic [IRQ_N-1:0]  IRQ;
  logic [2:0]        CMD;
  logic [DATA_W-1:0] D;
  logic              nVECT;
  logic              nOE;
  logic              nINT;

  modport master (output IRQ, output CMD, output D, output nVECT, output nOE, input nINT);
  modport slave  (input IRQ, input CMD, input D, input nVECT, input nOE, output nINT);

endinterface

// File: rtl/int_vector_ctl_prio_enc8.sv
// 8-bit priority encoder: reports the lowest set index and whether any bit is set.
module prio_enc8
  import int_pkg::*;
(
  input  logic [IRQ_N-1:0] i_req,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Lowest index wins.
  always_comb begin
    o_valid = |i_req;
    casez (i_req)
      8'b???????1: o_idx = 3'd0;
      8'b??????10: o_idx = 3'd1;
      8'b?????100: o_idx = 3'd2;
      8'b????1000: o_idx = 3'd3;
      8'b???10000: o_idx = 3'd4;
      8'b??100000: o_idx = 3'd5;
      8'b?1000000: o_idx = 3'd6;
      8'b10000000: o_idx = 3'd7;
      default:     o_idx = 3'd0;
    endcase
  end

endmodule

// File: rtl/int_vector_ctl.sv
// 8-input prioritised interrupt vector controller. Define INTVEC_NESTING_EN to
// allow a higher-priority request to interrupt one already in service.
module int_vector_ctl
  import int_pkg::*;
#(
  parameter logic [BASE_W-1:0] BASE_RESET = 6'h00
)(
  input  logic              clk,
  input  logic              nRESET,
  int_vector_ctl_if.slave   bus,
  output wire [DATA_W-1:0]  Y
);

  logic [IRQ_N-1:0]  r_irq_q, r_pending, r_isr, r_mask;
  logic [BASE_W-1:0] r_base;

  logic [IRQ_N-1:0]  w_edges, w_eligible, w_isr_eoi;
  logic [IRQ_N-1:0]  w_pend_nxt, w_isr_nxt, w_mask_nxt;
  logic [BASE_W-1:0] w_base_nxt;
  logic [IDX_W-1:0]  w_win_idx, w_isr_idx;
  logic              w_win_vld, w_isr_vld, w_spur, w_ack, w_nint;
  logic [DATA_W-1:0] w_vector, w_status, w_y;
  cmd_e              w_cmd;

  assign w_cmd      = cmd_e'(bus.CMD);
  assign w_edges    = bus.IRQ & ~r_irq_q;
  assign w_eligible = r_pending & ~r_mask;

  prio_enc8 u_win (.i_req(w_eligible), .o_idx(w_win_idx), .o_valid(w_win_vld));
  prio_enc8 u_lvl (.i_req(r_isr),      .o_idx(w_isr_idx), .o_valid(w_isr_vld));

  assign w_spur   = ~w_win_vld;
  assign w_vector = make_vector(r_base, w_spur, w_win_idx);
  assign w_status = {w_isr_vld, w_isr_idx, r_pending};

  // In-service set after an end-of-interrupt in this cycle.
  always_comb begin
    w_isr_eoi = r_isr;
    if ((w_cmd == CMD_EOI) && w_isr_vld) begin
      w_isr_eoi[w_isr_idx] = 1'b0;
    end else begin
      w_isr_eoi = r_isr;
    end
  end

`ifdef INTVEC_NESTING_EN
  assign w_nint = ~(w_win_vld & (~w_isr_vld | (w_win_idx < w_isr_idx)));
  assign w_ack  = ~bus.nVECT & w_win_vld;
`else
  // Single-level service: a fetch while another level is still open is ignored.
  assign w_nint = ~(w_win_vld & ~w_isr_vld);
  assign w_ack  = ~bus.nVECT & w_win_vld & ~(|w_isr_eoi);
`endif

  // Next-state for pending/in-service/mask/base from command and acknowledge.
  always_comb begin
    w_pend_nxt = r_pending;
    w_mask_nxt = r_mask;
    w_base_nxt = r_base;
    case (w_cmd)
      CMD_LOAD_MASK:  w_mask_nxt = bus.D[7:0];
      CMD_LOAD_BASE:  w_base_nxt = bus.D[11:6];
      CMD_CLEAR_PEND: w_pend_nxt = 8'h00;
      CMD_MASK_ALL:   w_mask_nxt = 8'hFF;
      CMD_UNMASK_ALL: w_mask_nxt = 8'h00;
      default:        w_pend_nxt = r_pending;
    endcase
    w_isr_nxt = w_isr_eoi;
    if (w_ack) begin
      w_pend_nxt[w_win_idx] = 1'b0;
      w_isr_nxt[w_win_idx]  = 1'b1;
    end else begin
      w_isr_nxt = w_isr_eoi;
    end
    // Edges arriving this cycle survive both acknowledge and CLEAR_PEND.
    w_pend_nxt = w_pend_nxt | w_edges;
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      r_irq_q   <= 8'h00;
      r_pending <= 8'h00;
      r_isr     <= 8'h00;
      r_mask    <= 8'hFF;
      r_base    <= BASE_RESET;
    end else begin
      r_irq_q   <= bus.IRQ;
      r_pending <= w_pend_nxt;
      r_isr     <= w_isr_nxt;
      r_mask    <= w_mask_nxt;
      r_base    <= w_base_nxt;
    end
  end

  // Output bus source select.
  always_comb begin
    if (!bus.nVECT) begin
      w_y = w_vector;
    end else if (w_cmd == CMD_READ) begin
      w_y = w_status;
    end else begin
      w_y = 12'h000;
    end
  end

  assign bus.nINT = w_nint;
  assign Y        = bus.nOE ? 12'hzzz : w_y;

endmodule

// File: doc/int_vector_ctl.md
INT_VECTOR_CTL -- requirements
Module: int_vector_ctl

Interface
REQ-001 SHALL have parameter BASE_RESET, default 6'h00, reset value of the vector base field.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port nRESET, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port IRQ, input, 8, interrupt request lines; index 0 has the highest priority.
REQ-005 SHALL have port CMD, input, 3, command code sampled each clock.
REQ-006 SHALL have port D, input, 12, command operand.
REQ-007 SHALL have port nVECT, input, 1, vector fetch strobe from the microprogram sequencer.
REQ-008 SHALL have port nOE, input, 1, Y tri-state enable.
REQ-009 SHALL have port Y, output, 12, vector or status bus.
REQ-010 SHALL have port nINT, output, 1, interrupt-pending condition for the sequencer CC input; low = take interrupt.

Function
REQ-011 SHALL set pending[i] on a rising edge of IRQ[i], detected against a registered copy of IRQ.
REQ-012 SHALL define eligible = pending & ~mask; winner = lowest eligible index; spur = no eligible bit.
REQ-013 SHALL drive nINT low combinationally when eligible is nonzero and winner index < lowest set ISR index, or ISR is empty.
REQ-014 SHALL form the vector as {base[5:0], spur, winner[2:0], 2'b00}; spurious vector uses winner = 3'b000.
REQ-015 SHALL drive Y = Z when nOE=1; else vector when nVECT=0; else status {|ISR, lowest ISR index[2:0], pending[7:0]} when CMD=READ; else 12'h000.
REQ-016 SHALL, on each clock with nVECT=0 and spur=0, clear pending[winner] and set ISR[winner]; one acknowledge per low cycle; spur=1 changes no state.
REQ-017 SHALL decode CMD: 000 NOP; 001 LOAD_MASK mask<=D[7:0]; 010 LOAD_BASE base<=D[11:6]; 011 EOI; 100 CLEAR_PEND pending<=0; 101 READ; 110 MASK_ALL mask<=8'hFF; 111 UNMASK_ALL mask<=8'h00.
REQ-018 SHALL, on EOI, clear the lowest-index set ISR bit; EOI with ISR empty has no effect.
REQ-019 SHALL, for EOI and acknowledge in one cycle, apply EOI first and then set the acknowledged bit.
REQ-020 SHALL, for a new IRQ[i] edge in the same cycle that acknowledges i, leave pending[i] set.
REQ-021 SHALL, for CLEAR_PEND in the same cycle as an acknowledge, still set ISR[winner]; new edges in that cycle remain pending.
REQ-022 SHALL allow LOAD_MASK in the acknowledge cycle; the acknowledge uses the pre-edge mask.

Reset
REQ-023 SHALL asynchronously set pending=0, ISR=0, mask=8'hFF, base=BASE_RESET, IRQ history=IRQ-inactive (0).
REQ-024 SHALL give nINT=1 and Y=12'h000 (nOE=0, nVECT=1, CMD≠READ) during and after reset until an unmasked edge.

Configuration
REQ-025 SHALL compile nested service only when INTVEC_NESTING_EN is defined; ISR holds several bits, per REQ-013.
REQ-026 SHALL, without INTVEC_NESTING_EN, hold nINT high whenever ISR is nonzero; at most one ISR bit is ever set.

Structure
REQ-027 SHALL place the CMD enumeration, IRQ count (8), and vector field widths in shared package int_pkg.
REQ-028 SHALL instantiate sub-module prio_enc8 (8-bit lowest-index priority encoder with valid) for the winner and ISR-level lookups.

Verification
REQ-029 SHALL check: reset, UNMASK_ALL, IRQ[3] rise -> nINT=0 next cycle; nVECT=0, base=0 -> Y=12'h00C; after the edge ISR=8'h08, pending=0.
REQ-030 SHALL check: LOAD_BASE D=12'hFC0, IRQ[0] and IRQ[5] rise together -> first vector 12'hFC0, second 12'hFD4.
REQ-031 SHALL check (nesting): ISR[4] set, IRQ[6] rise -> nINT=1; IRQ[2] rise -> nINT=0; without macro both keep nINT=1.
REQ-032 SHALL check: nVECT=0 with all masked -> Y=12'h020, no state change; EOI with empty ISR -> no change.
REQ-033 SHALL check: nRESET low mid-service (ISR=8'h01, pending=8'h10) -> immediate clear, mask=8'hFF, nINT=1.
